// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative encryptor
// and its on-the-fly key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [7:0] RCON_START = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // base: round key two words-groups back; tw: last word of the latest round key.
    function automatic logic [127:0] expand_key(input logic [127:0] base, input logic [31:0] tw,
                                                input logic [7:0] rcon, input logic rot);
        logic [31:0] t, w0, w1, w2, w3;
        t  = rot ? (sub_word(rot_word(tw)) ^ {rcon, 24'h0}) : sub_word(tw);
        w0 = base[127:96] ^ t;
        w1 = base[95:64] ^ w0;
        w2 = base[63:32] ^ w1;
        w3 = base[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// Block-level bus of the iterative AES encryptor: input/output handshakes plus
// status and FSM debug visibility.
interface aes_enc_iter_if
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
);
    // Valid/ready: a transfer happens on a rising edge where both are high; the
    // source holds valid and data stable until then, and ready never depends on valid.
    logic                in_valid;
    logic                in_ready;
    logic [KEY_BITS-1:0] key;
    logic [127:0]        text_in;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        text_out;
    logic                busy;
    fsm_state_t          dbg_state;

    modport master (
        output in_valid, key, text_in, out_ready,
        input  in_ready, out_valid, text_out, busy, dbg_state
    );

    modport slave (
        input  in_valid, key, text_in, out_ready,
        output in_ready, out_valid, text_out, busy, dbg_state
    );
endinterface

// File: rtl/aes_key_sched.sv
// On-the-fly AES round-key generator: one 128-bit round key per step, for
// AES-128 or AES-256.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [KEY_BITS-1:0] key_i,
    output logic [127:0]        rk_o
);
    localparam bit IS256 = (KEY_BITS == 256);

    logic [127:0] prev_q, prev_d;
    logic [127:0] cur_q, cur_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         even_q, even_d;

    // After load, cur holds rk[1] so it is ready for the first round.
    always_comb begin
        prev_d = prev_q;
        cur_d  = cur_q;
        rcon_d = rcon_q;
        even_d = even_q;
        if (load_i) begin
            prev_d = key_i[KEY_BITS-1 -: 128];
            even_d = 1'b1;
            if (IS256) begin
                cur_d  = key_i[127:0];
                rcon_d = RCON_START;
            end else begin
                cur_d  = expand_key(key_i[KEY_BITS-1 -: 128], key_i[31:0], RCON_START, 1'b1);
                rcon_d = xtime(RCON_START);
            end
        end else if (step_i) begin
            prev_d = cur_q;
            even_d = ~even_q;
            if (IS256) begin
                cur_d = expand_key(prev_q, cur_q[31:0], rcon_q, even_q);
                if (even_q) rcon_d = xtime(rcon_q);
            end else begin
                cur_d  = expand_key(cur_q, cur_q[31:0], rcon_q, 1'b1);
                rcon_d = xtime(rcon_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            cur_q  <= '0;
            rcon_q <= '0;
            even_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cur_q  <= cur_d;
            rcon_q <= rcon_d;
            even_q <= even_d;
        end
    end

    assign rk_o = cur_q;
endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor, one round per clock, with valid/ready on both sides
// and back-to-back acceptance straight out of DONE.
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic           clk,
    input  logic           rst,
    aes_enc_iter_if.slave  bus
);
    localparam int         NR   = nr_of(KEY_BITS);
    localparam logic [3:0] NR_L = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    fsm_state_t   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk, sr, mc;
    logic         in_ready_c, accept, last;

    assign accept = bus.in_valid & in_ready_c;
    assign last   = (rnd_q == NR_L);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c    = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.dbg_state = state_q;
        bus.text_out  = st_q;
    end

    aes_key_sched #(.KEY_BITS(KEY_BITS)) u_key_sched (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (state_q == RUN),
        .key_i  (bus.key),
        .rk_o   (rk)
    );

    // SubBytes+ShiftRows fused: byte (r,c) sits at bit 127-8*(4c+r).
    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = SBOX[st_q[127-8*(4*((c+r)%4)+r) -: 8]];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = last ? sr[127-32*c -: 32] : mix_col(sr[127-32*c -: 32]);
        end
    end

    always_comb begin
        st_d  = st_q;
        rnd_d = rnd_q;
        if (accept) begin
            st_d  = bus.text_in ^ bus.key[KEY_BITS-1 -: 128];
            rnd_d = 4'd1;
        end else if (state_q == RUN) begin
            st_d  = mc ^ rk;
            rnd_d = rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            rnd_q <= '0;
        end else begin
            st_q  <= st_d;
            rnd_q <= rnd_d;
        end
    end
endmodule
